btn_debounce: RTL and testbench



---
 rtl/btn_debounce_pkg.sv | 14 +
 rtl/btn_debounce_chan.sv | 146 ++++++++++++++
 rtl/btn_debounce.sv | 34 +++
 tb/tb_btn_debounce.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    REL        = 2'd0,
    WAIT_PRESS = 2'd1,
    PRS        = 2'd2,
    WAIT_REL   = 2'd3
  } deb_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int LONG_CYCLES_DEF     = 50000000;

endpackage

// File: rtl/btn_debounce_chan.sv
// One debounce channel: 2-FF synchroniser, stability FSM and optional hold counter.
// Long-press detection is built only when BTN_DEBOUNCE_LONGPRESS_EN is defined.
//
// state      | meaning
// REL        | output stable released (1)
// WAIT_PRESS | input low, counting stability before press
// PRS        | output stable pressed (0)
// WAIT_REL   | input high, counting stability before release
module btn_debounce_chan
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_out,
  output logic btn_fall,
  output logic btn_rise,
  output logic long_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
    $error("btn_debounce_chan: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
  end

  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s1_d, s2_q, s2_d;
  logic             btn_out_q, btn_out_d;
  logic             fall_q, fall_d, rise_q, rise_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      state_q   <= REL;
      cnt_q     <= '0;
      btn_out_q <= 1'b1;
      fall_q    <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_out_q <= btn_out_d;
      fall_q    <= fall_d;
      rise_q    <= rise_d;
    end
  end

  always_comb begin
    s1_d      = btn_raw;
    s2_d      = s1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    btn_out_d = btn_out_q;
    fall_d    = 1'b0;
    rise_d    = 1'b0;
    case (state_q)
      REL: begin
        if (!s2_q) begin
          state_d = WAIT_PRESS;
          cnt_d   = '0;
        end
      end
      // A reversal takes priority over the terminal count.
      WAIT_PRESS: begin
        if (s2_q) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = PRS;
          cnt_d     = '0;
          btn_out_d = 1'b0;
          fall_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRS: begin
        if (s2_q) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end
      end
      WAIT_REL: begin
        if (!s2_q) begin
          state_d = PRS;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = REL;
          cnt_d     = '0;
          btn_out_d = 1'b1;
          rise_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = REL;
    endcase
  end

  assign btn_out  = btn_out_q;
  assign btn_fall = fall_q;
  assign btn_rise = rise_q;

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  // Gating with btn_out_d drops long_press on the same edge as the release.
  always_comb begin
    hold_d = hold_q;
    if (btn_out_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
    end
    long_d = !btn_out_d && (hold_q == HOLD_MAX);
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer; one btn_debounce_chan per channel.
// Optional long-press flag enabled by BTN_DEBOUNCE_LONGPRESS_EN.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] btn_fall,
  output logic [WIDTH-1:0] btn_rise,
  output logic [WIDTH-1:0] long_press
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_raw   (btn_raw[i]),
      .btn_out   (btn_out[i]),
      .btn_fall  (btn_fall[i]),
      .btn_rise  (btn_rise[i]),
      .long_press(long_press[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce (WIDTH=2, DEBOUNCE_CYCLES=8, LONG_CYCLES=20).
module tb_btn_debounce;

  localparam int W  = 2;
  localparam int DC = 8;
  localparam int LC = 20;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] btn_raw;
  logic [W-1:0] btn_out, btn_fall, btn_rise, long_press;

  int checks   = 0;
  int failures = 0;
  int fall_cnt [W];
  int rise_cnt [W];
  int long_cnt [W];

  always #5 clk = ~clk;

  btn_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC),
    .LONG_CYCLES    (LC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_raw   (btn_raw),
    .btn_out   (btn_out),
    .btn_fall  (btn_fall),
    .btn_rise  (btn_rise),
    .long_press(long_press)
  );

  // One active edge, then sample on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < W; i++) begin
      if (btn_fall[i]) fall_cnt[i]++;
      if (btn_rise[i]) rise_cnt[i]++;
      if (long_press[i]) long_cnt[i]++;
    end
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < W; i++) begin
      fall_cnt[i] = 0;
      rise_cnt[i] = 0;
      long_cnt[i] = 0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    btn_raw = 2'b11;
    ticks(3);
    checks++;
    if (btn_out !== 2'b11) begin failures++; $display("FAIL reset_out_during got=%b want=11", btn_out); end
    checks++;
    if ({btn_fall, btn_rise, long_press} !== 6'b0) begin
      failures++; $display("FAIL reset_strobes_during got=%b want=000000", {btn_fall, btn_rise, long_press});
    end
    reset_n = 1'b1;
    clear_counts();
    ticks(4);
    checks++;
    if (btn_out !== 2'b11) begin failures++; $display("FAIL reset_out_after got=%b want=11", btn_out); end
    checks++;
    if (fall_cnt[0] + fall_cnt[1] + rise_cnt[0] + rise_cnt[1] + long_cnt[0] + long_cnt[1] != 0) begin
      failures++; $display("FAIL reset_strobes_after got=%0d want=0", fall_cnt[0] + fall_cnt[1] + rise_cnt[0] + rise_cnt[1]);
    end
  endtask

  task automatic test_clean_press();
    clear_counts();
    btn_raw = 2'b10;
    ticks(DC + 2);
    checks++;
    if (btn_out !== 2'b11 || btn_fall !== 2'b00) begin
      failures++; $display("FAIL press_early got out=%b fall=%b want out=11 fall=00", btn_out, btn_fall);
    end
    tick();
    checks++;
    if (btn_out !== 2'b10 || btn_fall !== 2'b01) begin
      failures++; $display("FAIL press_edge got out=%b fall=%b want out=10 fall=01", btn_out, btn_fall);
    end
    tick();
    checks++;
    if (btn_fall !== 2'b00 || btn_out !== 2'b10) begin
      failures++; $display("FAIL press_pulse_width got out=%b fall=%b want out=10 fall=00", btn_out, btn_fall);
    end
    btn_raw = 2'b11;
    ticks(DC + 3);
    checks++;
    if (btn_out !== 2'b11 || rise_cnt[0] != 1 || fall_cnt[1] != 0 || rise_cnt[1] != 0) begin
      failures++; $display("FAIL press_release got out=%b rise0=%0d fall1=%0d want out=11 rise0=1 fall1=0",
                           btn_out, rise_cnt[0], fall_cnt[1]);
    end
  endtask

  task automatic test_bounce_reject();
    int lows;
    clear_counts();
    lows = 0;
    btn_raw[0] = 1'b0;
    for (int j = 0; j < 5; j++) begin tick(); if (btn_out[0] !== 1'b1) lows++; end
    btn_raw[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin tick(); if (btn_out[0] !== 1'b1) lows++; end
    btn_raw[0] = 1'b0;
    for (int j = 0; j < 7; j++) begin tick(); if (btn_out[0] !== 1'b1) lows++; end
    btn_raw[0] = 1'b1;
    for (int j = 0; j < 20; j++) begin tick(); if (btn_out[0] !== 1'b1) lows++; end
    checks++;
    if (lows != 0) begin failures++; $display("FAIL bounce_out_low got=%0d want=0", lows); end
    checks++;
    if (fall_cnt[0] != 0 || rise_cnt[0] != 0) begin
      failures++; $display("FAIL bounce_strobes got fall=%0d rise=%0d want 0 0", fall_cnt[0], rise_cnt[0]);
    end
  endtask

  // Low for exactly DEBOUNCE_CYCLES is rejected; one cycle longer is accepted.
  task automatic test_boundary();
    clear_counts();
    btn_raw[0] = 1'b0;
    ticks(DC);
    btn_raw[0] = 1'b1;
    ticks(20);
    checks++;
    if (fall_cnt[0] != 0 || btn_out[0] !== 1'b1) begin
      failures++; $display("FAIL boundary_reject got fall=%0d out=%b want 0 1", fall_cnt[0], btn_out[0]);
    end
    btn_raw[0] = 1'b0;
    ticks(DC + 1);
    btn_raw[0] = 1'b1;
    ticks(2);
    checks++;
    if (fall_cnt[0] != 1 || btn_out[0] !== 1'b0) begin
      failures++; $display("FAIL boundary_accept got fall=%0d out=%b want 1 0", fall_cnt[0], btn_out[0]);
    end
    ticks(DC + 2);
    checks++;
    if (rise_cnt[0] != 1 || btn_out[0] !== 1'b1) begin
      failures++; $display("FAIL boundary_release got rise=%0d out=%b want 1 1", rise_cnt[0], btn_out[0]);
    end
  endtask

  task automatic test_bounce_settle();
    clear_counts();
    for (int j = 0; j < 3; j++) begin
      btn_raw[0] = 1'b0;
      ticks(2);
      btn_raw[0] = 1'b1;
      ticks(2);
    end
    btn_raw[0] = 1'b0;
    ticks(DC + 2);
    checks++;
    if (fall_cnt[0] != 0 || btn_out[0] !== 1'b1) begin
      failures++; $display("FAIL settle_early got fall=%0d out=%b want 0 1", fall_cnt[0], btn_out[0]);
    end
    tick();
    checks++;
    if (btn_fall !== 2'b01 || btn_out !== 2'b10) begin
      failures++; $display("FAIL settle_edge got fall=%b out=%b want 01 10", btn_fall, btn_out);
    end
    ticks(5);
    checks++;
    if (fall_cnt[0] != 1) begin failures++; $display("FAIL settle_count got=%0d want=1", fall_cnt[0]); end
    btn_raw[0] = 1'b1;
    ticks(DC + 3);
  endtask

  task automatic test_both_channels();
    clear_counts();
    btn_raw = 2'b00;
    ticks(DC + 3);
    checks++;
    if (btn_fall !== 2'b11 || btn_out !== 2'b00) begin
      failures++; $display("FAIL both_press got fall=%b out=%b want 11 00", btn_fall, btn_out);
    end
    ticks(3);
    btn_raw = 2'b10;
    ticks(DC + 2);
    checks++;
    if (btn_rise !== 2'b00 || btn_out !== 2'b00) begin
      failures++; $display("FAIL release1_early got rise=%b out=%b want 00 00", btn_rise, btn_out);
    end
    tick();
    checks++;
    if (btn_rise !== 2'b10 || btn_out !== 2'b10) begin
      failures++; $display("FAIL release1_edge got rise=%b out=%b want 10 10", btn_rise, btn_out);
    end
    btn_raw = 2'b11;
    ticks(DC + 3);
    checks++;
    if (btn_out !== 2'b11 || rise_cnt[0] != 1) begin
      failures++; $display("FAIL release0 got out=%b rise0=%0d want 11 1", btn_out, rise_cnt[0]);
    end
  endtask

  task automatic test_long_press();
    logic [W-1:0] exp_long;
    clear_counts();
    btn_raw = 2'b10;
    ticks(DC + 3);
    checks++;
    if (btn_fall !== 2'b01) begin failures++; $display("FAIL long_fall got=%b want=01", btn_fall); end
    ticks(LC - 1);
    checks++;
    if (long_press !== 2'b00) begin failures++; $display("FAIL long_early got=%b want=00", long_press); end
    tick();
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    exp_long = 2'b01;
`else
    exp_long = 2'b00;
`endif
    checks++;
    if (long_press !== exp_long) begin failures++; $display("FAIL long_assert got=%b want=%b", long_press, exp_long); end
    ticks(5);
    btn_raw = 2'b11;
    ticks(DC + 2);
    checks++;
    if (long_press !== exp_long || btn_out !== 2'b10) begin
      failures++; $display("FAIL long_hold got long=%b out=%b want %b 10", long_press, btn_out, exp_long);
    end
    tick();
    checks++;
    if (long_press !== 2'b00 || btn_rise !== 2'b01 || btn_out !== 2'b11) begin
      failures++; $display("FAIL long_clear got long=%b rise=%b out=%b want 00 01 11", long_press, btn_rise, btn_out);
    end
`ifndef BTN_DEBOUNCE_LONGPRESS_EN
    checks++;
    if (long_cnt[0] + long_cnt[1] != 0) begin
      failures++; $display("FAIL long_disabled got=%0d want=0", long_cnt[0] + long_cnt[1]);
    end
`endif
  endtask

  // Reset mid-wait aborts; a button held through reset release presses after normal latency.
  task automatic test_reset_abort();
    clear_counts();
    btn_raw = 2'b10;
    ticks(6);
    reset_n = 1'b0;
    ticks(2);
    checks++;
    if (btn_out !== 2'b11 || btn_fall !== 2'b00) begin
      failures++; $display("FAIL abort_in_reset got out=%b fall=%b want 11 00", btn_out, btn_fall);
    end
    clear_counts();
    reset_n = 1'b1;
    ticks(DC + 2);
    checks++;
    if (fall_cnt[0] != 0 || btn_out !== 2'b11) begin
      failures++; $display("FAIL abort_early got fall=%0d out=%b want 0 11", fall_cnt[0], btn_out);
    end
    tick();
    checks++;
    if (btn_fall !== 2'b01 || btn_out !== 2'b10) begin
      failures++; $display("FAIL held_through_reset got fall=%b out=%b want 01 10", btn_fall, btn_out);
    end
    btn_raw = 2'b11;
    ticks(DC + 3);
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_boundary();
    test_bounce_settle();
    test_both_channels();
    test_long_press();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
